seg_frame_scanner: RTL
======================

// Module: seg_frame_scanner
// PURPOSE
//   Double-buffered 8-digit frame store and multiplex scanner for the board's 7-segment display.
//   Pattern logic (group/count sequencer) writes digit codes into a back buffer over a valid/ready port.
//   It then pulses commit. The block swaps buffers only at a frame boundary, so the display never tears.
//   The front buffer is scanned one digit per slot onto segout/scanout, which drive the board pins.
// PARAMETERS
//   NUM_DIGITS    8     digits scanned per frame (2..8); scanout counts 0..NUM_DIGITS-1
//   REFRESH_DIV   6250  clk cycles per digit slot (>=2); at 50 MHz this gives 1 kHz per frame
//   BLANK_CYCLES  32    cycles at the start of each slot with segout forced to 0 (anti-ghosting); < REFRESH_DIV
// PORTS
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-low reset
//   wr_valid     in   1  write request
//   wr_ready     out  1  write accepted when wr_valid & wr_ready
//   wr_addr      in   3  digit index
//   wr_data      in   6  {blank, dp, hex[3:0]}
//   commit       in   1  one-cycle pulse: publish back buffer at next frame boundary
//   swap_done    out  1  one-cycle pulse on the cycle the front buffer is updated
//   frame_start  out  1  one-cycle pulse when the scan enters digit 0
//   segout       out  8  {dp,g,f,e,d,c,b,a}, active-high
//   scanout      out  3  index of the digit currently driven
// BEHAVIOUR
//   Reset (reset==0, async): front and back entries = blank (6'b100000), slot_cnt=0, digit=0, pending=0.
//     Outputs during reset: segout=0, scanout=0, wr_ready=1, swap_done=0, frame_start=0.
//   Prescaler: slot_cnt counts 0..REFRESH_DIV-1 and wraps.
//     On wrap, digit advances; it goes to 0 after NUM_DIGITS-1.
//   frame_start: pulses on the cycle digit becomes 0 (registered with digit). It does not pulse on reset exit.
//   scanout: equals digit, registered. It changes in the same cycle as slot_cnt returns to 0.
//   segout: registered. It is 0 while slot_cnt < BLANK_CYCLES or the entry's blank bit is set.
//     Otherwise it is decode(hex) with bit7 = dp. Latency from front buffer to segout is 1 cycle.
//   Hex decode (a..g), 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   Write port: wr_ready = ~pending.
//     An accepted write updates back[wr_addr] on the next edge.
//     If wr_addr >= NUM_DIGITS, the write is accepted and dropped.
//   Commit: if pending==0, pending<=1. A commit while pending==1 is ignored.
//     Write and commit in the same cycle: the write is accepted and included in the swap.
//   Swap: occurs on the edge where digit wraps NUM_DIGITS-1 -> 0, if pending==1.
//     front <= back (all digits); pending<=0; swap_done pulses that cycle, coincident with frame_start.
//     The new digit 0 shows the new data. The back buffer retains its contents after the swap.
//   Commit arriving on the wrap edge itself: pending is set and the swap happens at the following frame boundary.
//   Reset mid-operation: immediate return to reset state. pending is cleared, so an uncommitted frame is lost.
//   Width rules: slot_cnt is $clog2(REFRESH_DIV) bits; digit is 3 bits; compares are unsigned. No overflow paths.
// STRUCTURE
//   Package seg_pkg: SEG_* bit-position constants, BLANK_CODE (6'b100000), and the 16-entry hex-to-segment table.
//     The same package is used by the pattern sequencer.
//   Sub-module seg7_decode: combinational {blank,dp,hex} -> segout[7:0]. It is instantiated once, on the read mux.
//   Top: prescaler, digit counter, two NUM_DIGITS x 6 register arrays, pending flag, output registers.
// TESTING (bench parameters: REFRESH_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=8)
//   1. Reset only, release after 100 ns.
//      Required: segout stays 0 for 2 frames; scanout steps 0..7; a slot lasts 4 clk; frame_start every 32 clk.
//   2. Write addr0..7 = hex 0..7, dp=0, then commit.
//      Required: swap_done at the next digit-0 entry.
//      Then per digit: segout 00 for 1 cycle, then 3F,06,5B,4F,66,6D,7D,07.
//   3. Commit, then drive wr_valid until the swap.
//      Required: wr_ready=0 from the cycle after commit until the swap_done cycle;
//      front is unchanged before the swap; no write is lost or duplicated.
//   4. Write addr3 = {0,1,F} and commit in the same cycle.
//      Required: after the swap, digit 3 segout = 8'hF1. Write to addr 7'h? n/a; addr>=NUM_DIGITS with NUM_DIGITS=6: no effect.
//   5. Assert reset mid-slot while pending=1.
//      Required: outputs zero immediately (asynchronous); after release the display is blank and no swap_done occurs.
//   6. Two commits 5 cycles apart.
//      Required: a single swap_done; the second commit is ignored.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit-entry layout,
// the blank code and the hex-to-segment table used by the decoder and by
// the pattern sequencer.
package seg_pkg;

  // Segment bit positions inside segout {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Digit entry layout {blank, dp, hex[3:0]}
  localparam int ENT_BLANK = 5;
  localparam int ENT_DP    = 4;

  localparam logic [5:0] BLANK_CODE = 6'b100000;

  // a..g patterns for hex 0..F; entry 0 is the rightmost element
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return HEX_SEG[hex];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-entry decoder: {blank,dp,hex} -> {dp,g,f,e,d,c,b,a}.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] seg
);

  // A set blank bit darkens the whole digit, decimal point included
  always_comb begin
    seg = 8'h00;
    if (!code[ENT_BLANK]) begin
      seg[SEG_G:SEG_A] = hex_to_seg(code[3:0]);
      seg[SEG_DP]      = code[ENT_DP];
    end
  end

endmodule

// File: rtl/seg_frame_scanner.sv
// Double-buffered digit store with a multiplexed scan onto the 7-segment
// pins. Writes land in the back buffer; a commit publishes it to the front
// buffer only at the frame boundary so a frame is never shown half-updated.
module seg_frame_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 6250,
  parameter int BLANK_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [5:0] wr_data,
  input  logic       commit,
  output logic       swap_done,
  output logic       frame_start,
  output logic [7:0] segout,
  output logic [2:0] scanout
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LEN  = SW'(BLANK_CYCLES);
  localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [SW-1:0] slot_cnt, slot_nxt;
  logic [2:0]    digit, digit_nxt;
  logic          pending;
  logic [5:0]    front [NUM_DIGITS];
  logic [5:0]    back  [NUM_DIGITS];

  logic          slot_wrap, frame_wrap, swap_now, wr_fire;
  logic [5:0]    rd_entry, dec_in;
  logic [7:0]    seg_dec;

  assign wr_ready = ~pending;
  assign wr_fire  = wr_valid & ~pending;
  assign scanout  = digit;

  // Next-state of the scan position and the swap decision
  always_comb begin
    slot_wrap  = (slot_cnt == SLOT_LAST);
    slot_nxt   = slot_wrap ? '0 : slot_cnt + 1'b1;
    frame_wrap = slot_wrap && (digit == DIGIT_LAST);
    digit_nxt  = frame_wrap ? 3'd0 : (slot_wrap ? digit + 3'd1 : digit);
    swap_now   = frame_wrap & pending;
  end

  // Read mux for the digit shown next cycle; on a swap the new data is taken
  // straight from the back buffer so digit 0 never shows the stale frame
  always_comb begin
    rd_entry = BLANK_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_nxt == 3'(i)) rd_entry = swap_now ? back[i] : front[i];
    end
    dec_in = {rd_entry[ENT_BLANK] | (slot_nxt < BLANK_LEN), rd_entry[4:0]};
  end

  seg7_decode u_decode (
    .code (dec_in),
    .seg  (seg_dec)
  );

  // Prescaler, digit counter and commit/pending handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      digit    <= 3'd0;
      pending  <= 1'b0;
    end else begin
      slot_cnt <= slot_nxt;
      digit    <= digit_nxt;
      if (swap_now)    pending <= 1'b0;
      else if (commit) pending <= 1'b1;
    end
  end

  // Back buffer takes accepted writes; front buffer copies it at a swap.
  // Out-of-range addresses match no entry and are silently dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        front[i] <= BLANK_CODE;
        back[i]  <= BLANK_CODE;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_fire && (wr_addr == 3'(i))) back[i] <= wr_data;
        if (swap_now) front[i] <= back[i];
      end
    end
  end

  // Registered pin outputs and frame/swap pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      segout      <= 8'h00;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      segout      <= seg_dec;
      frame_start <= frame_wrap;
      swap_done   <= swap_now;
    end
  end

endmodule
